// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a word-wide data RAM without byte enables.
// Handles alignment/range checks, load extension and two-cycle read-modify-write for SB/SH.
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 524288
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        store_done,
  output logic        addr_err,
  output logic [31:0] err_addr
);

  localparam logic [2:0] OpLb  = 3'b000;
  localparam logic [2:0] OpLh  = 3'b001;
  localparam logic [2:0] OpLw  = 3'b010;
  localparam logic [2:0] OpLbu = 3'b011;
  localparam logic [2:0] OpLhu = 3'b100;
  localparam logic [2:0] OpSb  = 3'b101;
  localparam logic [2:0] OpSh  = 3'b110;
  localparam logic [2:0] OpSw  = 3'b111;

  localparam logic [31:0] MemLimit = 32'(MEM_BYTES);

  typedef enum logic [0:0] {StIdle, StRmwWr} state_e;

  state_e      state_q;
  logic        load_valid_q, store_done_q, addr_err_q;
  logic [31:0] load_data_q, err_addr_q;
  logic [31:0] rmw_addr_q, rmw_data_q;

  logic        accept, misaligned, out_of_range, legal;
  logic        is_load, is_rmw;
  logic [31:0] word_addr;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext, merged;

  assign req_ready    = (state_q == StIdle) & ~rst;
  assign accept       = req_valid & req_ready;
  assign word_addr    = {req_addr[31:2], 2'b00};
  assign is_load      = (req_op <= OpLhu);
  assign is_rmw       = (req_op == OpSb) | (req_op == OpSh);
  assign out_of_range = (req_addr >= MemLimit);
  assign legal        = ~misaligned & ~out_of_range;

  always_comb begin
    misaligned = 1'b0;
    unique case (req_op)
      OpLw, OpSw:        misaligned = (req_addr[1:0] != 2'b00);
      OpLh, OpLhu, OpSh: misaligned = req_addr[0];
      default:           misaligned = 1'b0;
    endcase
  end

  // Little-endian lane extraction and store merge, both against the word read this cycle.
  always_comb begin
    rd_byte  = ram_rdata[{req_addr[1:0], 3'b000} +: 8];
    rd_half  = req_addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    load_ext = 32'h0;
    unique case (req_op)
      OpLb:    load_ext = {{24{rd_byte[7]}}, rd_byte};
      OpLh:    load_ext = {{16{rd_half[15]}}, rd_half};
      OpLw:    load_ext = ram_rdata;
      OpLbu:   load_ext = {24'h0, rd_byte};
      OpLhu:   load_ext = {16'h0, rd_half};
      default: load_ext = 32'h0;
    endcase
    merged = ram_rdata;
    if (req_op == OpSb) begin
      merged[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
    end else if (req_addr[1]) begin
      merged[31:16] = req_wdata[15:0];
    end else begin
      merged[15:0] = req_wdata[15:0];
    end
  end

  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = 32'h0;
    ram_wdata = 32'h0;
    if (rst) begin
      ram_ce = 1'b0;
    end else if (state_q == StRmwWr) begin
      ram_ce    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = rmw_addr_q;
      ram_wdata = rmw_data_q;
    end else if (accept && legal) begin
      ram_ce   = 1'b1;
      ram_addr = word_addr;
      if (req_op == OpSw) begin
        ram_we    = 1'b1;
        ram_wdata = req_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      load_valid_q <= 1'b0;
      store_done_q <= 1'b0;
      addr_err_q   <= 1'b0;
      load_data_q  <= 32'h0;
      err_addr_q   <= 32'h0;
      rmw_addr_q   <= 32'h0;
      rmw_data_q   <= 32'h0;
    end else begin
      load_valid_q <= 1'b0;
      store_done_q <= 1'b0;
      addr_err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (!legal) begin
              addr_err_q <= 1'b1;
              err_addr_q <= req_addr;
            end else if (is_load) begin
              load_valid_q <= 1'b1;
              load_data_q  <= load_ext;
            end else if (is_rmw) begin
              rmw_addr_q <= word_addr;
              rmw_data_q <= merged;
              state_q    <= StRmwWr;
            end else begin
              store_done_q <= 1'b1;
            end
          end
        end
        StRmwWr: begin
          store_done_q <= 1'b1;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign load_valid = load_valid_q;
  assign load_data  = load_data_q;
  assign store_done = store_done_q;
  assign addr_err   = addr_err_q;
  assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table for single-cycle ops plus
// hand-written sequences for read-modify-write, back-to-back traffic and reset abort.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        load_valid, store_done, addr_err;
  logic [31:0] load_data, err_addr;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_BYTES(524288)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .ram_ce     (ram_ce),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .load_valid (load_valid),
    .load_data  (load_data),
    .store_done (store_done),
    .addr_err   (addr_err),
    .err_addr   (err_addr)
  );

  // Small RAM model aliased on addr[11:2]; a backdoor port preloads words.
  logic [31:0] mem [1024];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_idx = 10'h0;
  logic [31:0] bd_data = 32'h0;

  assign ram_rdata = mem[ram_addr[11:2]];

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (ram_ce && ram_we) mem[ram_addr[11:2]] <= ram_wdata;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bd_write(input logic [9:0] idx, input logic [31:0] data);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_data = data;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ce;
    logic        we;
    logic [31:0] raddr;
    logic        lv;
    logic [31:0] ldata;
    logic        sd;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{"lb_100",    3'd0, 32'h100,   32'h0,        1, 0, 32'h100,   1, 32'hFFFFFFBB, 0, 0};
    vecs[1]  = '{"lbu_103",   3'd3, 32'h103,   32'h0,        1, 0, 32'h100,   1, 32'h00000088, 0, 0};
    vecs[2]  = '{"lh_102",    3'd1, 32'h102,   32'h0,        1, 0, 32'h100,   1, 32'hFFFF8899, 0, 0};
    vecs[3]  = '{"lhu_100",   3'd4, 32'h100,   32'h0,        1, 0, 32'h100,   1, 32'h0000AABB, 0, 0};
    vecs[4]  = '{"lw_100",    3'd2, 32'h100,   32'h0,        1, 0, 32'h100,   1, 32'h8899AABB, 0, 0};
    vecs[5]  = '{"lw_102",    3'd2, 32'h102,   32'h0,        0, 0, 32'h0,     0, 32'h0,        0, 1};
    vecs[6]  = '{"sh_101",    3'd6, 32'h101,   32'hBEEF,     0, 0, 32'h0,     0, 32'h0,        0, 1};
    vecs[7]  = '{"sw_80000",  3'd7, 32'h80000, 32'h1,        0, 0, 32'h0,     0, 32'h0,        0, 1};
    vecs[8]  = '{"sw_104",    3'd7, 32'h104,   32'hDEADBEEF, 1, 1, 32'h104,   0, 32'h0,        1, 0};
    vecs[9]  = '{"lw_104",    3'd2, 32'h104,   32'h0,        1, 0, 32'h104,   1, 32'hDEADBEEF, 0, 0};
    vecs[10] = '{"lb_7ffff",  3'd0, 32'h7FFFF, 32'h0,        1, 0, 32'h7FFFC, 1, 32'hFFFFFF80, 0, 0};
    vecs[11] = '{"lhu_80001", 3'd4, 32'h80001, 32'h0,        0, 0, 32'h0,     0, 32'h0,        0, 1};

    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    bd_write(10'h040, 32'h8899AABB);
    bd_write(10'h041, 32'h0);
    bd_write(10'h3FF, 32'h80000000);
    #1;
    check("rst_ready", {31'h0, req_ready}, 32'h0);
    check("rst_ce", {31'h0, ram_ce}, 32'h0);
    @(negedge clk); rst = 1'b0; #1;
    check("init_ready", {31'h0, req_ready}, 32'h1);
    check("init_load_data", load_data, 32'h0);
    check("init_err_addr", err_addr, 32'h0);
    check("init_pulses", {29'h0, load_valid, store_done, addr_err}, 32'h0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].addr, vecs[i].wdata);
      #1;
      check({vecs[i].name, "/ce"}, {31'h0, ram_ce}, {31'h0, vecs[i].ce});
      check({vecs[i].name, "/we"}, {31'h0, ram_we}, {31'h0, vecs[i].we});
      if (vecs[i].ce) check({vecs[i].name, "/ram_addr"}, ram_addr, vecs[i].raddr);
      if (vecs[i].we) check({vecs[i].name, "/ram_wdata"}, ram_wdata, vecs[i].wdata);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check({vecs[i].name, "/load_valid"}, {31'h0, load_valid}, {31'h0, vecs[i].lv});
      check({vecs[i].name, "/store_done"}, {31'h0, store_done}, {31'h0, vecs[i].sd});
      check({vecs[i].name, "/addr_err"}, {31'h0, addr_err}, {31'h0, vecs[i].err});
      if (vecs[i].lv) check({vecs[i].name, "/load_data"}, load_data, vecs[i].ldata);
      if (vecs[i].err) check({vecs[i].name, "/err_addr"}, err_addr, vecs[i].addr);
      @(negedge clk); #1;
      check({vecs[i].name, "/pulse_len"}, {30'h0, load_valid, store_done}, 32'h0);
    end
    check("err_no_write", mem[10'h040], 32'h8899AABB);

    // SB read-modify-write
    @(negedge clk); drive(3'd5, 32'h101, 32'h123456CC); #1;
    check("sb/c0_ce_we", {30'h0, ram_ce, ram_we}, 32'h2);
    check("sb/c0_addr", ram_addr, 32'h100);
    @(negedge clk); req_valid = 1'b0; #1;
    check("sb/c1_ready", {31'h0, req_ready}, 32'h0);
    check("sb/c1_ce_we", {30'h0, ram_ce, ram_we}, 32'h3);
    check("sb/c1_addr", ram_addr, 32'h100);
    check("sb/c1_wdata", ram_wdata, 32'h8899CCBB);
    check("sb/c1_store_done", {31'h0, store_done}, 32'h0);
    @(negedge clk); #1;
    check("sb/c2_store_done", {31'h0, store_done}, 32'h1);
    check("sb/c2_ce", {31'h0, ram_ce}, 32'h0);
    @(negedge clk); drive(3'd2, 32'h100, 32'h0);
    @(negedge clk); req_valid = 1'b0; #1;
    check("sb/lw_valid", {31'h0, load_valid}, 32'h1);
    check("sb/lw_data", load_data, 32'h8899CCBB);

    // SH read-modify-write on the original word
    bd_write(10'h040, 32'h8899AABB);
    @(negedge clk); drive(3'd6, 32'h102, 32'h0000BEEF);
    @(negedge clk); req_valid = 1'b0; #1;
    check("sh/wdata", ram_wdata, 32'hBEEFAABB);
    @(negedge clk); #1;
    check("sh/store_done", {31'h0, store_done}, 32'h1);
    check("sh/mem", mem[10'h040], 32'hBEEFAABB);

    // Back-to-back LW, SW, LW
    bd_write(10'h040, 32'h8899AABB);
    @(negedge clk); drive(3'd2, 32'h100, 32'h0);
    @(negedge clk); drive(3'd7, 32'h100, 32'h11223344); #1;
    check("b2b/lw1_valid", {31'h0, load_valid}, 32'h1);
    check("b2b/lw1_data", load_data, 32'h8899AABB);
    check("b2b/sw_we", {31'h0, ram_we}, 32'h1);
    @(negedge clk); drive(3'd2, 32'h100, 32'h0); #1;
    check("b2b/sw_done", {31'h0, store_done}, 32'h1);
    check("b2b/gap_lv", {31'h0, load_valid}, 32'h0);
    @(negedge clk); req_valid = 1'b0; #1;
    check("b2b/lw2_valid", {31'h0, load_valid}, 32'h1);
    check("b2b/lw2_data", load_data, 32'h11223344);

    // Reset during RMW_WR aborts the write
    bd_write(10'h040, 32'h8899AABB);
    @(negedge clk); drive(3'd5, 32'h100, 32'h00000055);
    @(negedge clk); req_valid = 1'b0; rst = 1'b1; #1;
    check("rstrmw/we", {30'h0, ram_ce, ram_we}, 32'h0);
    @(negedge clk); rst = 1'b0; #1;
    check("rstrmw/ready", {31'h0, req_ready}, 32'h1);
    check("rstrmw/store_done", {31'h0, store_done}, 32'h0);
    check("rstrmw/load_data", load_data, 32'h0);
    check("rstrmw/mem", mem[10'h040], 32'h8899AABB);
    @(negedge clk); #1;
    check("rstrmw/late_done", {31'h0, store_done}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
